// File: rtl/riscv_irq_pkg.sv
// Shared constants and the saved-context frame for the interrupt sequencer.
package riscv_irq_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned VEC_STRIDE = 4;
  // Wide enough for the largest supported source count (16).
  localparam int unsigned IrqIdxW    = 4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [IrqIdxW-1:0] prev_irq;
  } irq_frame_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest set index of elig_i wins.
module irq_priority_encoder #(
  parameter int unsigned NUM_IRQ = 4,
  localparam int unsigned IdxW   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] elig_i,
  output logic [IdxW-1:0]    winner_o,
  output logic               valid_o
);

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        winner_o = IdxW'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: prioritised, nestable entry/return with a saved-PC stack,
// producing the final next PC combinationally for the synchronous-read fetch.
module irq_sequencer
  import riscv_irq_pkg::*;
#(
  parameter int unsigned         NUM_IRQ    = 4,
  parameter int unsigned         NEST_DEPTH = 2,
  parameter logic [NUM_IRQ-1:0]  EDGE_MODE  = '0,
  localparam int unsigned        IrqW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int unsigned        DepthW     = $clog2(NEST_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQ-1:0]   irq_sources,
  input  logic [NUM_IRQ-1:0]   irq_mask,
  input  logic [XLEN-1:0]      irq_vector_base,
  input  logic                 stall,
  input  logic                 cs_end_isr,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      pc_next,
  output logic [XLEN-1:0]      pc_next_final,
  output logic                 in_isr,
  output logic [IrqW-1:0]      active_irq,
  output logic [DepthW-1:0]    depth
);

  logic                first_cycle_q, first_cycle_d;
  logic [NUM_IRQ-1:0]  prev_q, prev_d;
  logic [NUM_IRQ-1:0]  edge_lat_q, edge_lat_d;
  logic [NUM_IRQ-1:0]  held_q, held_d;
  logic [DepthW-1:0]   depth_q, depth_d;
  logic [IrqW-1:0]     active_q, active_d;
  irq_frame_t          stack_q [NEST_DEPTH];
  irq_frame_t          stack_d [NEST_DEPTH];

  logic [NUM_IRQ-1:0]  pend, elig, fall, clr;
  logic [IrqW-1:0]     winner;
  logic                winner_valid;
  logic                take, pop;
  irq_frame_t          top_frame;

  assign fall = prev_q & ~irq_sources & EDGE_MODE;
  assign pend = (EDGE_MODE & edge_lat_q) | (~EDGE_MODE & (~irq_sources | held_q));
  assign elig = pend & irq_mask;

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .elig_i   (elig),
    .winner_o (winner),
    .valid_o  (winner_valid)
  );

  assign take = !first_cycle_q && !stall && !cs_end_isr && winner_valid
             && (depth_q < DepthW'(NEST_DEPTH))
             && ((depth_q == '0) || (winner < active_q));
  assign pop  = !first_cycle_q && !stall && cs_end_isr && (depth_q != '0);
  assign clr  = take ? (NUM_IRQ'(1) << winner) : '0;

  always_comb begin
    top_frame = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (DepthW'(i) == depth_q - DepthW'(1)) top_frame = stack_q[i];
    end
  end

  always_comb begin
    first_cycle_d = 1'b0;
    prev_d        = first_cycle_q ? prev_q : irq_sources;
    edge_lat_d    = first_cycle_q ? edge_lat_q : ((edge_lat_q & ~clr) | fall);
    held_d        = held_q & ~clr;
    if (!first_cycle_q && stall) held_d = held_d | (~irq_sources & ~EDGE_MODE);
    depth_d       = depth_q;
    active_d      = active_q;
    stack_d       = stack_q;
    if (take) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (DepthW'(i) == depth_q) begin
          stack_d[i].pc       = pc_next;
          stack_d[i].prev_irq = IrqIdxW'(active_q);
        end
      end
      depth_d  = depth_q + DepthW'(1);
      active_d = winner;
    end else if (pop) begin
      depth_d  = depth_q - DepthW'(1);
      active_d = IrqW'(top_frame.prev_irq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_cycle_q <= 1'b1;
      prev_q        <= '1;
      edge_lat_q    <= '0;
      held_q        <= '0;
      depth_q       <= '0;
      active_q      <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      first_cycle_q <= first_cycle_d;
      prev_q        <= prev_d;
      edge_lat_q    <= edge_lat_d;
      held_q        <= held_d;
      depth_q       <= depth_d;
      active_q      <= active_d;
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  always_comb begin
    if (first_cycle_q) begin
      pc_next_final = '0;
    end else if (stall) begin
      pc_next_final = pc;
    end else if (cs_end_isr && (depth_q != '0)) begin
      pc_next_final = top_frame.pc;
    end else if (take) begin
      pc_next_final = irq_vector_base + (XLEN'(winner) * XLEN'(VEC_STRIDE));
    end else begin
      pc_next_final = pc_next;
    end
  end

  assign in_isr     = (depth_q != '0);
  assign active_irq = active_q;
  assign depth      = depth_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench: three sequencer instances (default, single-level nest, edge ch0).
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_sources;
  logic [3:0]  irq_mask;
  logic [31:0] irq_vector_base;
  logic        stall;
  logic        cs_end_isr;
  logic [31:0] pc;
  logic [31:0] pc_next;

  logic [31:0] pcf0, pcf1, pcf2;
  logic        isr0, isr1, isr2;
  logic [1:0]  act0, act1, act2;
  logic [1:0]  dep0, dep2;
  logic [0:0]  dep1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_sequencer #(.NUM_IRQ(4), .NEST_DEPTH(2), .EDGE_MODE(4'b0000)) dut0 (
    .clk(clk), .reset(reset), .irq_sources(irq_sources), .irq_mask(irq_mask),
    .irq_vector_base(irq_vector_base), .stall(stall), .cs_end_isr(cs_end_isr),
    .pc(pc), .pc_next(pc_next), .pc_next_final(pcf0), .in_isr(isr0),
    .active_irq(act0), .depth(dep0)
  );

  irq_sequencer #(.NUM_IRQ(4), .NEST_DEPTH(1), .EDGE_MODE(4'b0000)) dut1 (
    .clk(clk), .reset(reset), .irq_sources(irq_sources), .irq_mask(irq_mask),
    .irq_vector_base(irq_vector_base), .stall(stall), .cs_end_isr(cs_end_isr),
    .pc(pc), .pc_next(pc_next), .pc_next_final(pcf1), .in_isr(isr1),
    .active_irq(act1), .depth(dep1)
  );

  irq_sequencer #(.NUM_IRQ(4), .NEST_DEPTH(2), .EDGE_MODE(4'b0001)) dut2 (
    .clk(clk), .reset(reset), .irq_sources(irq_sources), .irq_mask(irq_mask),
    .irq_vector_base(irq_vector_base), .stall(stall), .cs_end_isr(cs_end_isr),
    .pc(pc), .pc_next(pc_next), .pc_next_final(pcf2), .in_isr(isr2),
    .active_irq(act2), .depth(dep2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_sources     = 4'b1111;
    irq_mask        = 4'hF;
    irq_vector_base = 32'h100;
    stall           = 1'b0;
    cs_end_isr      = 1'b0;
    pc              = 32'h20;
    pc_next         = 32'h24;
  endtask

  // Leaves all instances just past their first cycle, between clock edges.
  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    pc_next = 32'h40;
    tick();
    tick();
    n_checks++; if (pcf0 !== 32'h0) begin n_fail++; $display("FAIL reset_pcf: got %h want 0", pcf0); end
    n_checks++; if (dep0 !== 2'd0 || isr0 !== 1'b0 || act0 !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: depth %0d in_isr %b act %0d want 0 0 0", dep0, isr0, act0);
    end
    reset = 1'b1;
    #1;
    n_checks++; if (pcf0 !== 32'h0) begin n_fail++; $display("FAIL first_cycle_pcf: got %h want 0", pcf0); end
    tick();
    #1;
    n_checks++; if (pcf0 !== 32'h40) begin n_fail++; $display("FAIL track_pc_next: got %h want 40", pcf0); end
    n_checks++; if (dep0 !== 2'd0) begin n_fail++; $display("FAIL idle_depth: got %0d want 0", dep0); end
  endtask

  task automatic test_basic_entry();
    do_reset();
    irq_sources = 4'b1011;
    #1;
    n_checks++; if (pcf0 !== 32'h108) begin n_fail++; $display("FAIL entry_vec: got %h want 108", pcf0); end
    tick();
    irq_sources = 4'b1111;
    pc = 32'h108; pc_next = 32'h10C;
    #1;
    n_checks++; if (dep0 !== 2'd1 || act0 !== 2'd2 || isr0 !== 1'b1) begin
      n_fail++; $display("FAIL entry_state: depth %0d act %0d in_isr %b want 1 2 1", dep0, act0, isr0);
    end
    cs_end_isr = 1'b1;
    #1;
    n_checks++; if (pcf0 !== 32'h24) begin n_fail++; $display("FAIL return_pc: got %h want 24", pcf0); end
    tick();
    cs_end_isr = 1'b0;
    #1;
    n_checks++; if (dep0 !== 2'd0 || isr0 !== 1'b0) begin
      n_fail++; $display("FAIL return_state: depth %0d in_isr %b want 0 0", dep0, isr0);
    end
  endtask

  task automatic test_nesting();
    do_reset();
    irq_sources = 4'b1011;
    tick();
    irq_sources = 4'b1110; pc_next = 32'h10C;
    #1;
    n_checks++; if (pcf0 !== 32'h100) begin n_fail++; $display("FAIL nest_vec: got %h want 100", pcf0); end
    tick();
    irq_sources = 4'b0111; pc_next = 32'h200;
    #1;
    n_checks++; if (dep0 !== 2'd2 || act0 !== 2'd0) begin
      n_fail++; $display("FAIL nest_state: depth %0d act %0d want 2 0", dep0, act0);
    end
    n_checks++; if (pcf0 !== 32'h200) begin n_fail++; $display("FAIL nest_full_hold: got %h want 200", pcf0); end
    tick();
    cs_end_isr = 1'b1;
    #1;
    n_checks++; if (pcf0 !== 32'h10C) begin n_fail++; $display("FAIL nest_ret1: got %h want 10c", pcf0); end
    tick();
    cs_end_isr = 1'b0; pc_next = 32'h110;
    #1;
    n_checks++; if (dep0 !== 2'd1 || act0 !== 2'd2 || pcf0 !== 32'h110) begin
      n_fail++; $display("FAIL nest_lowprio: depth %0d act %0d pcf %h want 1 2 110", dep0, act0, pcf0);
    end
    tick();
    cs_end_isr = 1'b1;
    #1;
    n_checks++; if (pcf0 !== 32'h24) begin n_fail++; $display("FAIL nest_ret2: got %h want 24", pcf0); end
    tick();
    cs_end_isr = 1'b0; pc_next = 32'h28;
    #1;
    n_checks++; if (dep0 !== 2'd0 || pcf0 !== 32'h10C) begin
      n_fail++; $display("FAIL nest_ch3_taken: depth %0d pcf %h want 0 10c", dep0, pcf0);
    end
    tick();
    irq_sources = 4'b1111;
    #1;
    n_checks++; if (dep0 !== 2'd1 || act0 !== 2'd3) begin
      n_fail++; $display("FAIL nest_ch3_state: depth %0d act %0d want 1 3", dep0, act0);
    end
  endtask

  task automatic test_depth_one();
    do_reset();
    irq_sources = 4'b1101;
    #1;
    n_checks++; if (pcf1 !== 32'h104) begin n_fail++; $display("FAIL d1_entry: got %h want 104", pcf1); end
    tick();
    irq_sources = 4'b1110; pc_next = 32'h108;
    #1;
    n_checks++; if (pcf1 !== 32'h108 || dep1 !== 1'b1) begin
      n_fail++; $display("FAIL d1_full: pcf %h depth %0d want 108 1", pcf1, dep1);
    end
    tick();
    cs_end_isr = 1'b1;
    #1;
    n_checks++; if (pcf1 !== 32'h24) begin n_fail++; $display("FAIL d1_return_wins: got %h want 24", pcf1); end
    tick();
    cs_end_isr = 1'b0; pc_next = 32'h30;
    #1;
    n_checks++; if (dep1 !== 1'b0 || pcf1 !== 32'h100) begin
      n_fail++; $display("FAIL d1_take_after: depth %0d pcf %h want 0 100", dep1, pcf1);
    end
    tick();
    irq_sources = 4'b1111;
    #1;
    n_checks++; if (dep1 !== 1'b1 || act1 !== 2'd0) begin
      n_fail++; $display("FAIL d1_state: depth %0d act %0d want 1 0", dep1, act1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    pc = 32'h50; pc_next = 32'h54; stall = 1'b1; irq_sources = 4'b1101;
    #1;
    n_checks++; if (pcf0 !== 32'h50) begin n_fail++; $display("FAIL stall_hold1: got %h want 50", pcf0); end
    tick();
    irq_sources = 4'b1111;
    #1;
    n_checks++; if (pcf0 !== 32'h50) begin n_fail++; $display("FAIL stall_hold2: got %h want 50", pcf0); end
    tick();
    stall = 1'b0; pc_next = 32'h58;
    #1;
    n_checks++; if (pcf0 !== 32'h104) begin n_fail++; $display("FAIL stall_held_take: got %h want 104", pcf0); end
    tick();
    cs_end_isr = 1'b1;
    #1;
    n_checks++; if (dep0 !== 2'd1 || act0 !== 2'd1 || pcf0 !== 32'h58) begin
      n_fail++; $display("FAIL stall_ret: depth %0d act %0d pcf %h want 1 1 58", dep0, act0, pcf0);
    end
    tick();
    cs_end_isr = 1'b0; pc_next = 32'h60;
    #1;
    n_checks++; if (pcf0 !== 32'h60 || dep0 !== 2'd0) begin
      n_fail++; $display("FAIL held_cleared: pcf %h depth %0d want 60 0", pcf0, dep0);
    end
  endtask

  task automatic test_edge();
    do_reset();
    irq_sources = 4'b1110;
    #1;
    n_checks++; if (pcf2 !== 32'h24) begin n_fail++; $display("FAIL edge_latency: got %h want 24", pcf2); end
    tick();
    #1;
    n_checks++; if (pcf2 !== 32'h100) begin n_fail++; $display("FAIL edge_take: got %h want 100", pcf2); end
    tick();
    pc_next = 32'h104;
    #1;
    n_checks++; if (dep2 !== 2'd1 || pcf2 !== 32'h104) begin
      n_fail++; $display("FAIL edge_once: depth %0d pcf %h want 1 104", dep2, pcf2);
    end
    tick();
    cs_end_isr = 1'b1;
    #1;
    n_checks++; if (pcf2 !== 32'h24) begin n_fail++; $display("FAIL edge_ret: got %h want 24", pcf2); end
    tick();
    cs_end_isr = 1'b0; pc_next = 32'h28;
    tick();
    #1;
    n_checks++; if (dep2 !== 2'd0 || pcf2 !== 32'h28) begin
      n_fail++; $display("FAIL edge_no_reentry: depth %0d pcf %h want 0 28", dep2, pcf2);
    end
    irq_sources = 4'b1111;
    tick();
    cs_end_isr = 1'b1;
    #1;
    n_checks++; if (pcf2 !== 32'h28) begin n_fail++; $display("FAIL ret_idle_pcf: got %h want 28", pcf2); end
    tick();
    cs_end_isr = 1'b0;
    #1;
    n_checks++; if (dep2 !== 2'd0 || isr2 !== 1'b0 || act2 !== 2'd0) begin
      n_fail++; $display("FAIL ret_idle_state: depth %0d in_isr %b act %0d want 0 0 0", dep2, isr2, act2);
    end
    stall = 1'b1; pc = 32'h80; irq_sources = 4'b1110;
    tick();
    stall = 1'b0; irq_sources = 4'b1111; pc_next = 32'h84;
    #1;
    n_checks++; if (pcf2 !== 32'h100) begin n_fail++; $display("FAIL edge_in_stall: got %h want 100", pcf2); end
  endtask

  task automatic test_reset_mid_isr();
    do_reset();
    irq_sources = 4'b1011;
    tick();
    irq_sources = 4'b1111;
    reset = 1'b0;
    #1;
    n_checks++; if (dep0 !== 2'd0 || pcf0 !== 32'h0 || act0 !== 2'd0) begin
      n_fail++; $display("FAIL reset_mid_isr: depth %0d pcf %h act %0d want 0 0 0", dep0, pcf0, act0);
    end
    reset = 1'b1;
    tick();
    cs_end_isr = 1'b1; pc_next = 32'h90;
    #1;
    n_checks++; if (pcf0 !== 32'h90) begin n_fail++; $display("FAIL stack_discarded: got %h want 90", pcf0); end
    cs_end_isr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_nesting();
    test_depth_one();
    test_stall();
    test_edge();
    test_reset_mid_isr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
